// File: rtl/screen_probe_matcher_if.sv
// Video-side bundle for screen_probe_matcher: decoded DVI timing and pixel
// inputs travelling towards the detector, and the detector's status outputs
// travelling back.
interface screen_probe_matcher_if #(
  parameter int NUM_PROBES = 4
) ();
  logic                  enable;
  logic                  vsync;
  logic                  hsync;
  logic                  vde;
  logic [23:0]           rgb_pixel;
  logic                  detected;
  logic [NUM_PROBES-1:0] match_mask;
  logic                  frame_valid;

  // Video source / status consumer side.
  modport master (
    output enable, vsync, hsync, vde, rgb_pixel,
    input  detected, match_mask, frame_valid
  );

  // Detector side.
  modport slave (
    input  enable, vsync, hsync, vde, rgb_pixel,
    output detected, match_mask, frame_valid
  );
endinterface

// File: rtl/screen_probe_matcher.sv
// Screen-state detector. Samples NUM_PROBES fixed pixel positions per frame,
// compares each against a reference colour within a per-channel tolerance,
// and debounces the per-frame all-probes-hit result into a stable flag.
module screen_probe_matcher #(
  parameter int                       NUM_PROBES     = 4,
  parameter logic [NUM_PROBES*11-1:0] PROBE_X        = '0,
  parameter logic [NUM_PROBES*10-1:0] PROBE_Y        = '0,
  parameter logic [NUM_PROBES*24-1:0] PROBE_RGB      = '0,
  parameter logic [7:0]               TOL            = 8'd4,
  parameter int                       CONFIRM_FRAMES = 3,
  parameter int                       RELEASE_FRAMES = 2
) (
  input logic                   CLK,
  input logic                   RST_N,
  screen_probe_matcher_if.slave vid
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [10:0] X_MAX       = 11'd2047;
  localparam logic [9:0]  Y_MAX       = 10'd1023;
  localparam logic [3:0]  CONFIRM_CNT = 4'(CONFIRM_FRAMES);
  localparam logic [3:0]  RELEASE_CNT = 4'(RELEASE_FRAMES);

  // Raster position and per-frame hit tracking.
  logic [10:0]           x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic                  vde_d_q, vde_d_d;
  logic [NUM_PROBES-1:0] hit_q, hit_d;
  logic [NUM_PROBES-1:0] pix_hit;

  // Debounce state and registered outputs.
  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  primed_q;
  logic                  detected_q;
  logic [NUM_PROBES-1:0] match_mask_q;
  logic                  frame_valid_q;

  logic                  frame_pass;
  logic [3:0]            cnt_inc;

  // |a-b| on one 8-bit channel, widened to 9 bits so the subtraction
  // can never wrap, compared inclusively against the tolerance.
  function automatic logic chan_ok(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] diff;
    diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return diff <= {1'b0, TOL};
  endfunction

  // Per-probe match of the pixel currently on the bus at the current raster
  // position; qualification by vde/hsync/vsync happens in the datapath below.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    pix_hit = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      if ((x_q == PROBE_X[11*i +: 11]) &&
          (y_q == PROBE_Y[10*i +: 10]) &&
          chan_ok(vid.rgb_pixel[23:16], PROBE_RGB[24*i+16 +: 8]) &&
          chan_ok(vid.rgb_pixel[15:8],  PROBE_RGB[24*i+8  +: 8]) &&
          chan_ok(vid.rgb_pixel[7:0],   PROBE_RGB[24*i    +: 8])) begin
        pix_hit[i] = 1'b1;
      end
    end
  end

  // Next raster position and sticky hit state. vsync outranks hsync, which
  // outranks vde, so a colliding pixel is never compared.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    hit_d   = hit_q;
    vde_d_d = vid.vde;
    if (!vid.enable) begin
      x_d     = '0;
      y_d     = '0;
      hit_d   = '0;
      vde_d_d = 1'b0;
    end else if (vid.vsync) begin
      // The line in flight at vsync belongs to the frame just closed, so its
      // falling edge must not advance y in the new frame.
      x_d     = '0;
      y_d     = '0;
      hit_d   = '0;
      vde_d_d = 1'b0;
    end else begin
      if (vid.hsync) begin
        x_d = '0;
      end else if (vid.vde && (x_q != X_MAX)) begin
        x_d = x_q + 11'd1;
      end
      if (vde_d_q && !vid.vde && (y_q != Y_MAX)) begin
        y_d = y_q + 10'd1;
      end
      if (vid.vde && !vid.hsync) begin
        hit_d = hit_q | pix_hit;
      end
    end
  end

  // Raster/hit registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_q     <= '0;
      y_q     <= '0;
      vde_d_q <= 1'b0;
      hit_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      x_q     <= x_d;
      y_q     <= y_d;
      vde_d_q <= vde_d_d;
      hit_q   <= hit_d;
    end
  end

  assign frame_pass = &hit_q;
  assign cnt_inc    = cnt_q + 4'd1;

  // Frame evaluation and confirm/release debounce FSM with registered outputs.
  // The first vsync after reset or enable only primes the block.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      primed_q      <= 1'b0;
      detected_q    <= 1'b0;
      match_mask_q  <= '0;
      frame_valid_q <= 1'b0;
    end else if (!vid.enable) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      primed_q      <= 1'b0;
      detected_q    <= 1'b0;
      match_mask_q  <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (vid.vsync) begin
        primed_q <= 1'b1;
        if (primed_q) begin
          match_mask_q  <= hit_q;
          frame_valid_q <= 1'b1;
          case (state_q)
            ST_IDLE: begin
              if (!frame_pass) begin
                cnt_q <= '0;
              end else if (cnt_inc == CONFIRM_CNT) begin
                state_q    <= ST_ACTIVE;
                cnt_q      <= '0;
                detected_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end
            ST_ACTIVE: begin
              if (frame_pass) begin
                cnt_q <= '0;
              end else if (cnt_inc == RELEASE_CNT) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                detected_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end
            default: begin
              state_q    <= ST_IDLE;
              cnt_q      <= '0;
              detected_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign vid.detected    = detected_q;
  assign vid.match_mask  = match_mask_q;
  assign vid.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_screen_probe_matcher.sv
// Self-checking bench for screen_probe_matcher: a directed vector table,
// hand-written reset/enable/collision sequences, and randomized frames scored
// against a frame-level reference model.
module tb_screen_probe_matcher;

  localparam int          NP         = 2;
  localparam int          PROBE_LINE = 605;
  localparam int          X0         = 83;
  localparam int          X1         = 366;
  localparam logic [23:0] REF0       = 24'h387300;
  localparam logic [23:0] REF1       = 24'hD5D500;
  localparam logic [23:0] BG         = 24'h000000;
  localparam int          TOL_V      = 4;
  localparam int          CONF       = 3;
  localparam int          REL        = 2;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  screen_probe_matcher_if #(.NUM_PROBES(NP)) vid ();

  screen_probe_matcher #(
    .NUM_PROBES     (NP),
    .PROBE_X        ({11'd366, 11'd83}),
    .PROBE_Y        ({10'd605, 10'd605}),
    .PROBE_RGB      ({REF1, REF0}),
    .TOL            (8'd4),
    .CONFIRM_FRAMES (CONF),
    .RELEASE_FRAMES (REL)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .vid   (vid)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          n_lines;
    int          len;
    logic [23:0] p0;
    logic [23:0] p1;
    logic [1:0]  exp_mask;
    logic        exp_det;
  } vec_t;

  vec_t vecs[18];

  // Reference model state: current flag and length of the run of frames
  // disagreeing with it since the last change.
  logic m_det;
  int   m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    vid.vsync     = 1'b0;
    vid.hsync     = 1'b0;
    vid.vde       = 1'b0;
    vid.rgb_pixel = BG;
  endtask

  task automatic pixel(input logic [23:0] c);
    vid.vsync     = 1'b0;
    vid.hsync     = 1'b0;
    vid.vde       = 1'b1;
    vid.rgb_pixel = c;
    tick();
  endtask

  task automatic hs();
    vid.vsync     = 1'b0;
    vid.hsync     = 1'b1;
    vid.vde       = 1'b0;
    vid.rgb_pixel = BG;
    tick();
    vid.hsync = 1'b0;
  endtask

  // One line: hsync cycle (vde low, closes the previous line) then len pixels.
  task automatic drive_line(input int len, input logic [23:0] p0, input logic [23:0] p1);
    hs();
    for (int k = 0; k < len; k++) begin
      pixel((k == X0) ? p0 : ((k == X1) ? p1 : BG));
    end
  endtask

  // coll: 0 normal, 1 hsync+vde on the probe-0 pixel then restart the line,
  // 2 vsync+vde on the probe-0 pixel (ends the frame there).
  task automatic drive_frame(input int n_lines, input int len, input logic [23:0] p0,
                             input logic [23:0] p1, input int coll);
    for (int l = 0; l < n_lines; l++) begin
      if (l != PROBE_LINE) begin
        drive_line(1, BG, BG);
      end else if (coll == 0) begin
        drive_line(len, p0, p1);
      end else begin
        hs();
        for (int k = 0; k < X0; k++) pixel(BG);
        if (coll == 1) begin
          vid.hsync = 1'b1; vid.vde = 1'b1; vid.rgb_pixel = p0;
          tick();
          for (int k = 0; k <= X1; k++) pixel((k == X1) ? p1 : BG);
        end else begin
          vid.vsync = 1'b1; vid.vde = 1'b1; vid.rgb_pixel = p0;
          tick();
          idle();
          return;
        end
      end
    end
    vid.vsync = 1'b1; vid.vde = 1'b0; vid.hsync = 1'b0; vid.rgb_pixel = BG;
    tick();
    idle();
  endtask

  function automatic logic close(input logic [23:0] a, input logic [23:0] b);
    for (int c = 0; c < 3; c++) begin
      int d;
      d = int'(a[8*c +: 8]) - int'(b[8*c +: 8]);
      if (d < 0) d = -d;
      if (d > TOL_V) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Which probes a frame with this content should report as hit.
  function automatic logic [1:0] model_mask(input int n_lines, input int len,
                                            input logic [23:0] p0, input logic [23:0] p1,
                                            input int coll);
    logic [1:0] m;
    logic reached;
    reached = (n_lines > PROBE_LINE);
    m = 2'b00;
    if (coll == 0) begin
      m[0] = reached && (len > X0) && close(p0, REF0);
      m[1] = reached && (len > X1) && close(p1, REF1);
    end else if (coll == 1) begin
      m[1] = reached && close(p1, REF1);
    end
    return m;
  endfunction

  task automatic model_step(input logic pass);
    if (pass != m_det) m_run++;
    else               m_run = 0;
    if (!m_det && (m_run == CONF)) begin
      m_det = 1'b1;
      m_run = 0;
    end else if (m_det && (m_run == REL)) begin
      m_det = 1'b0;
      m_run = 0;
    end
  endtask

  // Called just after the vsync edge of an evaluating frame.
  task automatic check_eval(input string tag, input logic [1:0] m, input logic d);
    check({tag, " frame_valid"}, 32'(vid.frame_valid), 32'd1);
    check({tag, " match_mask"},  32'(vid.match_mask),  32'(m));
    check({tag, " detected"},    32'(vid.detected),    32'(d));
    tick();
    check({tag, " frame_valid_one_cycle"}, 32'(vid.frame_valid), 32'd0);
  endtask

  function automatic vec_t mk(input int n, input int l, input logic [23:0] a,
                              input logic [23:0] b, input logic [1:0] m, input logic d);
    vec_t v;
    v.n_lines = n; v.len = l; v.p0 = a; v.p1 = b; v.exp_mask = m; v.exp_det = d;
    return v;
  endfunction

  function automatic logic [23:0] jitter(input logic [23:0] r, input int span);
    logic [23:0] o;
    for (int c = 0; c < 3; c++) begin
      int v;
      v = int'(r[8*c +: 8]) + int'($urandom_range(0, 2 * span)) - span;
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      o[8*c +: 8] = 8'(v);
    end
    return o;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed table: starts in IDLE right after the priming vsync.
    vecs[0]  = mk(606, 367, REF0,         REF1,         2'b11, 1'b0);
    vecs[1]  = mk(606, 367, REF0,         REF1,         2'b11, 1'b0);
    vecs[2]  = mk(606, 367, REF0,         REF1,         2'b11, 1'b1);
    vecs[3]  = mk(606, 367, 24'h3C7300,   REF1,         2'b11, 1'b1);
    vecs[4]  = mk(606, 367, REF0,         24'hD5D505,   2'b01, 1'b1);
    vecs[5]  = mk(606, 367, 24'h386F00,   24'hD5D900,   2'b11, 1'b1);
    vecs[6]  = mk(600, 367, REF0,         REF1,         2'b00, 1'b1);
    vecs[7]  = mk(606, 200, REF0,         REF1,         2'b01, 1'b0);
    vecs[8]  = mk(606, 367, REF0,         REF1,         2'b11, 1'b0);
    vecs[9]  = mk(606, 367, REF0,         24'hD5D504,   2'b11, 1'b0);
    vecs[10] = mk(606, 367, 24'h3D7300,   REF1,         2'b10, 1'b0);
    vecs[11] = mk(606, 367, REF0,         REF1,         2'b11, 1'b0);
    vecs[12] = mk(606, 367, REF0,         REF1,         2'b11, 1'b0);
    vecs[13] = mk(606, 367, 24'h337300,   REF1,         2'b10, 1'b0);
    vecs[14] = mk(600, 367, REF0,         REF1,         2'b00, 1'b0);
    vecs[15] = mk(606, 367, REF0,         REF1,         2'b11, 1'b0);
    vecs[16] = mk(606, 367, REF0,         REF1,         2'b11, 1'b0);
    vecs[17] = mk(606, 367, REF0,         REF1,         2'b11, 1'b1);

    RST_N = 1'b0;
    vid.enable = 1'b0;
    idle();
    tick();
    check("reset detected",    32'(vid.detected),    32'd0);
    check("reset match_mask",  32'(vid.match_mask),  32'd0);
    check("reset frame_valid", 32'(vid.frame_valid), 32'd0);
    tick();
    RST_N = 1'b1;
    vid.enable = 1'b1;
    tick();

    // Priming frame: its vsync must not evaluate.
    drive_frame(606, 367, REF0, REF1, 0);
    check("prime frame_valid", 32'(vid.frame_valid), 32'd0);

    for (int i = 0; i < 18; i++) begin
      drive_frame(vecs[i].n_lines, vecs[i].len, vecs[i].p0, vecs[i].p1, 0);
      check_eval($sformatf("vec%0d", i), vecs[i].exp_mask, vecs[i].exp_det);
    end

    // Asynchronous reset mid-frame while detected is high.
    for (int l = 0; l < 300; l++) drive_line(1, BG, BG);
    RST_N = 1'b0;
    #1;
    check("async reset detected",    32'(vid.detected),    32'd0);
    check("async reset match_mask",  32'(vid.match_mask),  32'd0);
    check("async reset frame_valid", 32'(vid.frame_valid), 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    drive_frame(606, 367, REF0, REF1, 0);
    check("post-reset first vsync frame_valid", 32'(vid.frame_valid), 32'd0);
    drive_frame(606, 367, REF0, REF1, 0);
    check_eval("post-reset second vsync", 2'b11, 1'b0);

    // Enable low clears outputs; first vsync after it rises only primes.
    vid.enable = 1'b0;
    tick();
    check("disable match_mask",  32'(vid.match_mask),  32'd0);
    check("disable detected",    32'(vid.detected),    32'd0);
    check("disable frame_valid", 32'(vid.frame_valid), 32'd0);
    tick();
    tick();
    vid.enable = 1'b1;
    drive_frame(606, 367, REF0, REF1, 0);
    check("post-enable first vsync frame_valid", 32'(vid.frame_valid), 32'd0);
    m_det = 1'b0;
    m_run = 0;

    // Randomized frames against the reference model.
    for (int f = 0; f < 12; f++) begin
      int n, len;
      logic [23:0] p0, p1;
      logic [1:0] m;
      n   = ($urandom_range(0, 9) == 0) ? 600 : 606;
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(84, 366)) : 400;
      p0  = jitter(REF0, ($urandom_range(0, 3) == 0) ? 7 : 4);
      p1  = jitter(REF1, ($urandom_range(0, 3) == 0) ? 7 : 4);
      drive_frame(n, len, p0, p1, 0);
      m = model_mask(n, len, p0, p1, 0);
      model_step(&m);
      check_eval($sformatf("rand%0d", f), m, m_det);
    end

    // Collisions: hsync+vde and vsync+vde on the probe-0 pixel.
    begin
      logic [1:0] m;
      drive_frame(606, 0, REF0, REF1, 1);
      m = model_mask(606, 0, REF0, REF1, 1);
      model_step(&m);
      check_eval("hsync collision", m, m_det);

      drive_frame(606, 0, REF0, REF1, 2);
      m = model_mask(606, 0, REF0, REF1, 2);
      model_step(&m);
      check_eval("vsync collision", m, m_det);

      drive_frame(606, 367, BG, REF1, 0);
      m = model_mask(606, 367, BG, REF1, 0);
      model_step(&m);
      check_eval("after vsync collision", m, m_det);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_probe_matcher.md
# screen_probe_matcher

Generalised screen-state detector for the Autocaster video path. It samples NUM_PROBES programmable pixel positions in each frame of the decoded DVI stream and compares each sample against a reference colour within a per-channel tolerance. A frame-level result is debounced with confirm and release hysteresis into a stable `detected` flag. It sits beside the sync edge detectors in the pixel-clock domain, and its flag feeds the screen_detector status register.

## Interface
Parameters:
- NUM_PROBES, 4: number of probe points, legal range 1..8.
- PROBE_X, 0: packed NUM_PROBES×11-bit x coordinates; probe i is at [11i+10:11i].
- PROBE_Y, 0: packed NUM_PROBES×10-bit y coordinates.
- PROBE_RGB, 0: packed NUM_PROBES×24-bit reference colours, {R,G,B}.
- TOL, 8'd4: allowed absolute difference per 8-bit channel, inclusive.
- CONFIRM_FRAMES, 3: consecutive passing frames required to assert `detected`, range 1..15.
- RELEASE_FRAMES, 2: consecutive failing frames required to deassert `detected`, range 1..15.

Ports:
- CLK  in  1  pixel clock.
- RST_N  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; low holds all state at reset values.
- vsync  in  1  single-cycle start-of-frame pulse.
- hsync  in  1  single-cycle start-of-line pulse.
- vde  in  1  video data enable.
- rgb_pixel  in  24  pixel value, {R,G,B}; valid while vde is high.
- detected  out  1  debounced screen-match flag.
- match_mask  out  NUM_PROBES  per-probe hit result of the last completed frame.
- frame_valid  out  1  one-cycle pulse when match_mask and the frame result update.

## Operation
- Counters:
  - x (11 bit) is the index of the current active pixel. Reset by hsync; increments by 1 on each vde cycle and saturates at 2047.
  - y (10 bit) is the index of the current active line. Reset by vsync; increments on the vde falling edge (registered vde_d=1, vde=0) and saturates at 1023.
- Probe compare: when vde=1, x==PROBE_X[i] and y==PROBE_Y[i], the block computes |R-Rref|, |G-Gref| and |B-Bref| as 9-bit differences. hit[i] sets if all three are ≤ TOL.
- hit[i] is sticky for the rest of the frame. A probe whose position is never reached stays 0, so the frame counts as failing.
- Frame evaluation on the vsync pulse:
  - match_mask <= hit; frame_pass = &hit; frame_valid <= 1.
  - Clear hit, x and y.
- Debounce state machine, with a 4-bit counter cnt:
  - IDLE (detected=0): on pass, cnt++. When cnt reaches CONFIRM_FRAMES, go to ACTIVE with cnt=0. On fail, cnt=0.
  - ACTIVE (detected=1): on fail, cnt++. When cnt reaches RELEASE_FRAMES, go to IDLE with cnt=0. On pass, cnt=0.
- The first vsync after reset or after enable rises is a sync-only edge. It clears the counters and hit state but does not evaluate, because there is no complete frame before it. A primed flag tracks this.
- Simultaneous events:
  - vsync with vde: vsync wins; the pixel is not compared and x and y clear.
  - hsync with vde: hsync wins; the pixel is not compared and x<=0.
  - vsync with hsync: treated as vsync only.
- enable=0: state is IDLE, cnt=0, hit=0, x=y=0, primed=0, and all outputs are 0. Checked synchronously every cycle.
- RST_N low at any time, including mid-frame: all registers clear asynchronously. The first frame after release is sync-only.

## Timing
- All outputs are registered. Reset values: detected=0, match_mask=0, frame_valid=0.
- Pixel-to-hit latency: the hit is registered one cycle after the matching vde cycle.
- A pixel arriving in the cycle immediately before vsync is included in that frame.
- vsync pulse at cycle t:
  - match_mask and frame_valid are visible at t+1.
  - The state and detected update at t+1, from the frame_pass computed at t.
  - frame_valid is high only at t+1.
- Minimum assert latency: CONFIRM_FRAMES passing frames after priming; detected rises at t+1 of the CONFIRM_FRAMES-th evaluating vsync.

## Test plan
- Reset and enable: RST_N=0 mid-frame with detected=1 → detected=0, match_mask=0 immediately (asynchronous). After release, the first vsync gives no frame_valid; the second gives frame_valid=1.
- Exact-match assert: NUM_PROBES=2, probes (83,605)=24'h387300 and (366,605)=24'hD5D500, matching pixels, CONFIRM=3 → match_mask=2'b11 every frame, detected=1 at t+1 of the 3rd evaluating vsync, not earlier.
- Tolerance edge, TOL=4: R off by 4 → hit. R off by 5 → miss, match_mask=2'b10 (probe 0 only failing), and the confirm counter resets.
- Release hysteresis, RELEASE=2: with detected=1, send pass, fail, pass, fail, fail → detected stays 1 until t+1 of the second consecutive fail.
- Truncated frame: probe at y=605 but vsync after 600 lines → hit=0, frame fails, detected never asserts.
- Collisions: hsync coinciding with vde on a probe pixel, and vsync coinciding with vde on a probe pixel → no hit recorded. x restarts at 0, so the next vde pixel is x=0.
